// File: rtl/tx_8b10b_serializer_pkg.sv
// Shared types and constants for the 8b/10b transmit path.
// Symbols are carried as {K, HGFEDCBA}; line codes as 10 bits with bit 'a' at index 0.
package enc8b10b_pkg;

  typedef logic [8:0] sym9_t;
  typedef logic [9:0] sym10_t;

  localparam sym9_t K28_5 = 9'h1BC;
  localparam sym9_t K28_1 = 9'h13C;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_EOB  = 1'b1
  } state_t;

  // Data symbols are always encodable; only a small set of control symbols exists.
  function automatic logic is_legal_k(sym9_t s);
    logic [4:0] x;
    logic [2:0] y;
    x = s[4:0];
    y = s[7:5];
    return !s[8] || (x == 5'd28) ||
           ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

endpackage

// File: rtl/tx_8b10b_serializer_if.sv
// Word-side handshake and serial-side outputs of the 8b/10b transmitter.
interface tx_8b10b_serializer_if;
  import enc8b10b_pkg::*;

  sym9_t data_i;
  logic  valid_i;
  logic  eob_i;
  logic  ready_o;
  logic  serialdata_o;
  logic  sos_o;
  logic  kerr_o;

  modport master (
    output data_i, valid_i, eob_i,
    input  ready_o, serialdata_o, sos_o, kerr_o
  );

  modport slave (
    input  data_i, valid_i, eob_i,
    output ready_o, serialdata_o, sos_o, kerr_o
  );

endinterface

// File: rtl/tx_8b10b_serializer_encoder.sv
// Combinational 8b/10b encoder: 5b/6b and 3b/4b tables with running disparity.
// The output code has bit 'a' at index 0 so it can be shifted out LSB first.
module enc8b10b_encoder
  import enc8b10b_pkg::*;
(
  input  sym9_t  sym,
  input  logic   rd_in,
  output sym10_t code,
  output logic   rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k;
  logic       k28;
  logic       alt7;
  logic [5:0] six_n, six_p, six;
  logic [3:0] four_n, four_p, four;
  logic       rd_mid;
  logic [9:0] abcdeifghj;

  assign x   = sym[4:0];
  assign y   = sym[7:5];
  assign k   = sym[8];
  assign k28 = k && (x == 5'd28);

  // 5b/6b table, abcdei with 'a' as MSB; _n is the RD- column, _p the RD+ column.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    six_n = 6'b000000;
    six_p = 6'b000000;
    unique case (x)
      5'd0:  begin six_n = 6'b100111; six_p = 6'b011000; end
      5'd1:  begin six_n = 6'b011101; six_p = 6'b100010; end
      5'd2:  begin six_n = 6'b101101; six_p = 6'b010010; end
      5'd3:  begin six_n = 6'b110001; six_p = 6'b110001; end
      5'd4:  begin six_n = 6'b110101; six_p = 6'b001010; end
      5'd5:  begin six_n = 6'b101001; six_p = 6'b101001; end
      5'd6:  begin six_n = 6'b011001; six_p = 6'b011001; end
      5'd7:  begin six_n = 6'b111000; six_p = 6'b000111; end
      5'd8:  begin six_n = 6'b111001; six_p = 6'b000110; end
      5'd9:  begin six_n = 6'b100101; six_p = 6'b100101; end
      5'd10: begin six_n = 6'b010101; six_p = 6'b010101; end
      5'd11: begin six_n = 6'b110100; six_p = 6'b110100; end
      5'd12: begin six_n = 6'b001101; six_p = 6'b001101; end
      5'd13: begin six_n = 6'b101100; six_p = 6'b101100; end
      5'd14: begin six_n = 6'b011100; six_p = 6'b011100; end
      5'd15: begin six_n = 6'b010111; six_p = 6'b101000; end
      5'd16: begin six_n = 6'b011011; six_p = 6'b100100; end
      5'd17: begin six_n = 6'b100011; six_p = 6'b100011; end
      5'd18: begin six_n = 6'b010011; six_p = 6'b010011; end
      5'd19: begin six_n = 6'b110010; six_p = 6'b110010; end
      5'd20: begin six_n = 6'b001011; six_p = 6'b001011; end
      5'd21: begin six_n = 6'b101010; six_p = 6'b101010; end
      5'd22: begin six_n = 6'b011010; six_p = 6'b011010; end
      5'd23: begin six_n = 6'b111010; six_p = 6'b000101; end
      5'd24: begin six_n = 6'b110011; six_p = 6'b001100; end
      5'd25: begin six_n = 6'b100110; six_p = 6'b100110; end
      5'd26: begin six_n = 6'b010110; six_p = 6'b010110; end
      5'd27: begin six_n = 6'b110110; six_p = 6'b001001; end
      5'd28: begin six_n = 6'b001110; six_p = 6'b001110; end
      5'd29: begin six_n = 6'b101110; six_p = 6'b010001; end
      5'd30: begin six_n = 6'b011110; six_p = 6'b100001; end
      5'd31: begin six_n = 6'b101011; six_p = 6'b010100; end
      default: ;
    endcase
  end

  always_comb begin
    if (k28) six = rd_in ? 6'b110000 : 6'b001111;
    else     six = rd_in ? six_p : six_n;
    rd_mid = ($countones(six) == 3) ? rd_in : ($countones(six) > 3);
  end

  // The alternate x.7 form avoids a run of five equal bits across the sub-block boundary.
  assign alt7 = k ||
                (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

  // 3b/4b table, fghj with 'f' as MSB; columns selected by the disparity after the 6b block.
  always_comb begin
    four_n = 4'b0000;
    four_p = 4'b0000;
    if (k28) begin
      unique case (y)
        3'd0: begin four_n = 4'b1011; four_p = 4'b0100; end
        3'd1: begin four_n = 4'b0110; four_p = 4'b1001; end
        3'd2: begin four_n = 4'b1010; four_p = 4'b0101; end
        3'd3: begin four_n = 4'b1100; four_p = 4'b0011; end
        3'd4: begin four_n = 4'b1101; four_p = 4'b0010; end
        3'd5: begin four_n = 4'b0101; four_p = 4'b1010; end
        3'd6: begin four_n = 4'b1001; four_p = 4'b0110; end
        3'd7: begin four_n = 4'b0111; four_p = 4'b1000; end
        default: ;
      endcase
    end else begin
      unique case (y)
        3'd0: begin four_n = 4'b1011; four_p = 4'b0100; end
        3'd1: begin four_n = 4'b1001; four_p = 4'b1001; end
        3'd2: begin four_n = 4'b0101; four_p = 4'b0101; end
        3'd3: begin four_n = 4'b1100; four_p = 4'b0011; end
        3'd4: begin four_n = 4'b1101; four_p = 4'b0010; end
        3'd5: begin four_n = 4'b1010; four_p = 4'b1010; end
        3'd6: begin four_n = 4'b0110; four_p = 4'b0110; end
        3'd7: begin
          four_n = alt7 ? 4'b0111 : 4'b1110;
          four_p = alt7 ? 4'b1000 : 4'b0001;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    four       = rd_mid ? four_p : four_n;
    rd_out     = ($countones(four) == 2) ? rd_mid : ($countones(four) > 2);
    abcdeifghj = {six, four};
    code       = '0;
    for (int i = 0; i < 10; i++) code[i] = abcdeifghj[9-i];
  end

endmodule

// File: rtl/tx_8b10b_serializer.sv
// 8b/10b transmitter: accepts {K,HGFEDCBA} words, encodes with running disparity and
// shifts each 10-bit symbol out bit 'a' first, filling gaps with commas and closing blocks.
module tx_8b10b_serializer
  import enc8b10b_pkg::*;
#(
  parameter sym9_t IDLE_K = K28_5,
  parameter sym9_t EOB_K  = K28_1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tx_8b10b_serializer_if.slave  bus
);

  logic [3:0] bit_cnt;
  sym10_t     shreg;
  logic       rd;
  state_t     state;
  logic       sos_q;
  logic       kerr_q;

  logic       load;
  sym9_t      sel_sym;
  logic       sel_kerr;
  sym10_t     enc_code;
  logic       enc_rd;

  assign load = (bit_cnt == 4'd9);

  // Symbol choice for the next load edge; an unencodable K request degrades to a comma.
  always_comb begin
    sel_sym  = IDLE_K;
    sel_kerr = 1'b0;
    if (state == ST_EOB) begin
      sel_sym = EOB_K;
    end else if (bus.valid_i) begin
      if (is_legal_k(bus.data_i)) sel_sym = bus.data_i;
      else                        sel_kerr = 1'b1;
    end
  end

  enc8b10b_encoder u_enc (
    .sym    (sel_sym),
    .rd_in  (rd),
    .code   (enc_code),
    .rd_out (enc_rd)
  );

  // RD is committed only on load edges, so a symbol's disparity is fixed for all its ten bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= 4'd9;
      shreg   <= '0;
      rd      <= 1'b0;
      state   <= ST_DATA;
      sos_q   <= 1'b0;
      kerr_q  <= 1'b0;
    end else if (load) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      bit_cnt <= 4'd0;
      shreg   <= enc_code;
      rd      <= enc_rd;
      sos_q   <= 1'b1;
      kerr_q  <= sel_kerr;
      if (state == ST_EOB)                 state <= ST_DATA;
      else if (bus.valid_i && bus.eob_i)   state <= ST_EOB;
      else                                 state <= ST_DATA;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
      shreg   <= shreg >> 1;
      sos_q   <= 1'b0;
      kerr_q  <= 1'b0;
    end
  end

  assign bus.serialdata_o = shreg[0];
  assign bus.sos_o        = sos_q;
  assign bus.kerr_o       = kerr_q;
  assign bus.ready_o      = load && (state == ST_DATA) && !rst_i;

endmodule

// File: tb/tb_tx_8b10b_serializer.sv
// Self-checking bench: a queue-based line model compared every cycle, plus literal symbol checks.
module tb_tx_8b10b_serializer;
  import enc8b10b_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tx_8b10b_serializer_if bus ();

  tx_8b10b_serializer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // RD- forms; the RD+ form is the complement whenever the sub-block is unbalanced (or x.7 / y.3).
  logic [5:0] six_tab [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] four_tab [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                               4'b1101, 4'b1010, 4'b0110, 4'b1110};

  localparam logic [9:0] C_K28_5_N = 10'b0011111010;
  localparam logic [9:0] C_K28_5_P = 10'b1100000101;
  localparam logic [9:0] C_K28_1_N = 10'b0011111001;
  localparam logic [9:0] C_K28_1_P = 10'b1100000110;

  // Returns abcdeifghj with 'a' as the MSB (line order, left to right).
  function automatic logic [9:0] model_enc(input logic [8:0] s, input logic rd_in,
                                           output logic rd_out);
    logic [5:0] six;
    logic [3:0] four;
    logic       r;
    logic       k28;
    logic       a7;
    k28 = s[8] && (s[4:0] == 5'd28);
    six = k28 ? 6'b001111 : six_tab[s[4:0]];
    if (rd_in && (($countones(six) != 3) || (s[4:0] == 5'd7))) six = ~six;
    r = ($countones(six) == 3) ? rd_in : ($countones(six) > 3);
    a7 = (s[7:5] == 3'd7) && (s[8] || (!r && (s[4:0] inside {5'd17, 5'd18, 5'd20})) ||
                                      ( r && (s[4:0] inside {5'd11, 5'd13, 5'd14})));
    four = a7 ? 4'b0111 : four_tab[s[7:5]];
    if (r && (($countones(four) != 2) || (s[7:5] == 3'd3) || (s[7:5] == 3'd7))) four = ~four;
    if (k28 && !r && (s[7:5] inside {3'd1, 3'd2, 3'd5, 3'd6})) four = ~four;
    rd_out = ($countones(four) == 2) ? r : ($countones(four) > 2);
    return {six, four};
  endfunction

  function automatic logic model_legal(input logic [8:0] s);
    return !s[8] || (s inside {9'h11C, 9'h13C, 9'h15C, 9'h17C, 9'h19C, 9'h1BC, 9'h1DC, 9'h1FC,
                               9'h1F7, 9'h1FB, 9'h1FD, 9'h1FE});
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Line model: a queue of pending line bits, refilled whenever it runs dry.
  bit         line_q[$];
  logic       m_rd = 1'b0;
  logic       m_eob = 1'b0;
  logic       exp_serial = 1'b0;
  logic       exp_sos = 1'b0;
  logic       exp_kerr = 1'b0;

  initial begin
    logic [8:0] sym;
    logic [9:0] code;
    logic       nrd;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        line_q.delete();
        m_rd = 1'b0; m_eob = 1'b0;
        exp_serial = 1'b0; exp_sos = 1'b0; exp_kerr = 1'b0;
      end else begin
        exp_sos  = 1'b0;
        exp_kerr = 1'b0;
        if (line_q.size() == 0) begin
          if (m_eob) begin
            sym = 9'h13C; m_eob = 1'b0;
          end else if (bus.valid_i) begin
            sym = bus.data_i;
            if (!model_legal(sym)) begin sym = 9'h1BC; exp_kerr = 1'b1; end
            if (bus.eob_i) m_eob = 1'b1;
          end else begin
            sym = 9'h1BC;
          end
          code = model_enc(sym, m_rd, nrd);
          m_rd = nrd;
          for (int i = 9; i >= 0; i--) line_q.push_back(code[i]);
          exp_sos = 1'b1;
        end
        exp_serial = line_q.pop_front();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_bit("serialdata", bus.serialdata_o, exp_serial);
      check_bit("sos", bus.sos_o, exp_sos);
      check_bit("kerr", bus.kerr_o, exp_kerr);
      check_bit("ready", bus.ready_o, (line_q.size() == 0) && !m_eob && !rst);
    end
  end

  // Receiver side: reassemble symbols on sos and track line disparity like a decoder would.
  logic [9:0] rx_syms[$];
  initial begin
    int         rx_n = 0;
    logic [9:0] rx_sh = '0;
    logic       rx_rd = 1'b0;
    logic       ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_n = 0; rx_rd = 1'b0;
      end else begin
        if (bus.sos_o) begin
          rx_sh = {9'b0, bus.serialdata_o}; rx_n = 1;
        end else if (rx_n > 0) begin
          rx_sh = {rx_sh[8:0], bus.serialdata_o}; rx_n++;
        end
        if (rx_n == 10) begin
          rx_syms.push_back(rx_sh);
          rx_n = 0;
          ok = 1'b0;
          if ($countones(rx_sh) == 5) ok = 1'b1;
          else if (($countones(rx_sh) == 6) && !rx_rd) begin ok = 1'b1; rx_rd = 1'b1; end
          else if (($countones(rx_sh) == 4) &&  rx_rd) begin ok = 1'b1; rx_rd = 1'b0; end
          check_bit("rx_disparity", ok, 1'b1);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one word at a load slot whose RD matches want_rd (-1 = any); idx = its symbol index.
  task automatic send(input logic [8:0] w, input logic e, input int want_rd, output int idx);
    int waited = 0;
    @(negedge clk);
    while (!(bus.ready_o && ((want_rd < 0) || (m_rd == want_rd[0]))) && (waited < 60)) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 60) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: word %h never accepted", w);
      idx = -1;
    end else begin
      bus.data_i = w; bus.valid_i = 1'b1; bus.eob_i = e;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0; bus.eob_i = 1'b0;
      idx = rx_syms.size();
    end
  endtask

  task automatic check_sym(input string name, input int idx, input logic [9:0] e1,
                           input logic [9:0] e2);
    n_vec++;
    if ((idx < 0) || (idx >= rx_syms.size())) begin
      n_err++;
      $display("FAIL %s: symbol %0d not received (%0d received)", name, idx, rx_syms.size());
    end else if ((rx_syms[idx] !== e1) && (rx_syms[idx] !== e2)) begin
      n_err++;
      $display("FAIL %s: got %b expected %b or %b", name, rx_syms[idx], e1, e2);
    end
  endtask

  initial begin
    int         i, i0, i1, i2, base, waited;
    logic       r;
    bus.data_i = '0; bus.valid_i = 1'b0; bus.eob_i = 1'b0;
    #2 rst = 1'b1;
    wait_cycles(3);
    check_bit("reset_serial", bus.serialdata_o, 1'b0);
    check_bit("reset_ready", bus.ready_o, 1'b0);

    check_vec("model_k28_5_neg", model_enc(9'h1BC, 1'b0, r), C_K28_5_N);
    check_vec("model_k28_5_pos", model_enc(9'h1BC, 1'b1, r), C_K28_5_P);
    check_vec("model_d0_0_neg",  model_enc(9'h000, 1'b0, r), 10'b1001110100);
    check_vec("model_d11_7_pos", model_enc(9'h0EB, 1'b1, r), 10'b1101001000);

    rst = 1'b0;
    wait_cycles(25);
    check_sym("t1_comma_neg", 0, C_K28_5_N, C_K28_5_N);
    check_sym("t1_comma_pos", 1, C_K28_5_P, C_K28_5_P);

    send(9'h000, 1'b0, 0, i);
    wait_cycles(22);
    check_sym("t2_d0_0_neg", i, 10'b1001110100, 10'b1001110100);
    check_sym("t2_rd_kept_neg", i + 1, C_K28_5_N, C_K28_5_N);

    send(9'h0B5, 1'b0, 0, i);
    wait_cycles(12);
    check_sym("t3_d21_5_neg", i, 10'b1010101010, 10'b1010101010);
    send(9'h0B5, 1'b0, 1, i);
    wait_cycles(12);
    check_sym("t3_d21_5_pos", i, 10'b1010101010, 10'b1010101010);

    send(9'h0EB, 1'b0, 1, i);
    wait_cycles(12);
    check_sym("t4_d11_7_a7_pos", i, 10'b1101001000, 10'b1101001000);
    send(9'h0F1, 1'b0, 0, i);
    wait_cycles(12);
    check_sym("t4_d17_7_a7_neg", i, 10'b1000110111, 10'b1000110111);

    send(9'h055, 1'b0, -1, i0);
    send(9'h0AA, 1'b0, -1, i1);
    send(9'h0F0, 1'b1, -1, i2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_bit("t5_ready_low_eob_load", bus.ready_o, 1'b0);
    check_bit("t5_back_to_back", (i1 == i0 + 1) && (i2 == i1 + 1), 1'b1);
    wait_cycles(25);
    check_sym("t5_eob_k28_1", i2 + 1, C_K28_1_N, C_K28_1_P);
    check_sym("t5_idle_after_eob", i2 + 2, C_K28_5_N, C_K28_5_P);

    send(9'h100, 1'b0, -1, i);
    @(negedge clk);
    check_bit("t6_kerr_pulse", bus.kerr_o, 1'b1);
    @(negedge clk);
    check_bit("t6_kerr_clear", bus.kerr_o, 1'b0);
    wait_cycles(12);
    check_sym("t6_illegal_k_idle", i, C_K28_5_N, C_K28_5_P);

    send(9'h101, 1'b1, -1, i);
    wait_cycles(25);
    check_sym("t6_illegal_k_eob_idle", i, C_K28_5_N, C_K28_5_P);
    check_sym("t6_illegal_k_eob_k28_1", i + 1, C_K28_1_N, C_K28_1_P);

    // Reset while bit 4 of a comma is on the line.
    waited = 0;
    @(negedge clk);
    while (!bus.sos_o && (waited < 30)) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 30) begin
      n_vec++; n_err++;
      $display("FAIL t6_sos_timeout: no start of symbol seen");
    end
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("t6_rst_serial", bus.serialdata_o, 1'b0);
    check_bit("t6_rst_sos", bus.sos_o, 1'b0);
    check_bit("t6_rst_ready", bus.ready_o, 1'b0);
    wait_cycles(2);
    rst = 1'b0;
    base = rx_syms.size();
    wait_cycles(12);
    check_sym("t6_restart_comma_neg", base, C_K28_5_N, C_K28_5_N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
